// File: rtl/jtframe_prog_pkg.sv
// Shared types and constants for the ROM download packer.
// FSM states, bank indices and active-low byte-lane masks.
package jtframe_prog_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [1:0] BANK0 = 2'd0;
    localparam logic [1:0] BANK1 = 2'd1;
    localparam logic [1:0] BANK2 = 2'd2;
    localparam logic [1:0] BANK3 = 2'd3;

    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;
    localparam logic [1:0] MASK_NONE = 2'b11;

    localparam int AW = 27;
    localparam int EW = AW + 8;

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Synchronous FIFO with fill level; async active-low reset empties it.
// Storage is not reset, only the pointers and the level.
module jtframe_prog_fifo #(
    parameter int FW = 4,
    parameter int DW = 35
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [FW:0]   level
);

    localparam logic [FW:0] DEPTH = (FW+1)'(2**FW);

    logic [DW-1:0] mem [2**FW];
    logic [FW-1:0] wr_ptr;
    logic [FW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = level == DEPTH;
    assign empty   = level == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (!do_push && do_pop) level <= level - 1'b1;
        end
    end

endmodule

// File: rtl/jtframe_prog_packer.sv
// Buffers download bytes and turns them into SDRAM bank/word writes.
// JTFRAME_PROG_SWAP_EN swaps the byte lanes for big-endian ROM sets.
module jtframe_prog_packer
    import jtframe_prog_pkg::*;
#(
    parameter int          FW        = 4,
    parameter logic [26:0] BA1_START = 27'h10_0000,
    parameter logic [26:0] BA2_START = 27'h20_0000,
    parameter logic [26:0] BA3_START = 27'h30_0000,
    parameter logic [26:0] ROM_END   = 27'h40_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic        ioctl_rom_wr,
    input  logic [26:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_rdy,
    output logic        prog_we,
    input  logic        prog_rdy,
    output logic [1:0]  prog_ba,
    output logic [21:0] prog_addr,
    output logic [15:0] prog_data,
    output logic [1:0]  prog_mask,
    output logic        dwnld_busy,
    output logic        overflow
);

    localparam logic [FW:0] RDY_LVL = (FW+1)'(2**FW - 2);

    state_t          state;
    state_t          next;
    logic            pop;
    logic            full;
    logic            empty;
    logic [FW:0]     level;
    logic [EW-1:0]   ent;
    logic [26:0]     ent_addr;
    logic [7:0]      ent_byte;
    logic [1:0]      ent_bank;
    logic [26:0]     ent_start;
    logic [22:0]     ent_off;
    logic [1:0]      ent_mask;
    logic            ent_drop;
    logic            dl_q;
    logic            dl_rise;

    jtframe_prog_fifo #(.FW(FW), .DW(EW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ioctl_rom_wr),
        .din   ({ioctl_addr, ioctl_dout}),
        .pop   (pop),
        .dout  (ent),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign ioctl_rdy = level < RDY_LVL;
    assign prog_we   = state == WRITE;
    assign dl_rise   = downloading & ~dl_q;
    assign ent_addr  = ent[EW-1:8];
    assign ent_byte  = ent[7:0];
    assign ent_drop  = ent_addr >= ROM_END;

    always_comb begin
        ent_bank  = BANK0;
        ent_start = '0;
        if (ent_addr >= BA3_START) begin
            ent_bank  = BANK3;
            ent_start = BA3_START;
        end else if (ent_addr >= BA2_START) begin
            ent_bank  = BANK2;
            ent_start = BA2_START;
        end else if (ent_addr >= BA1_START) begin
            ent_bank  = BANK1;
            ent_start = BA1_START;
        end
        ent_off = 23'(ent_addr - ent_start);
`ifdef JTFRAME_PROG_SWAP_EN
        ent_mask = ent_addr[0] ? MASK_LO : MASK_HI;
`else
        ent_mask = ent_addr[0] ? MASK_HI : MASK_LO;
`endif
    end

    always_comb begin
        next = state;
        pop  = 1'b0;
        unique case (state)
            IDLE:    if (!empty) next = POP;
            POP: begin
                pop  = 1'b1;
                next = ent_drop ? IDLE : WRITE;
            end
            WRITE:   if (prog_rdy) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_ba   <= '0;
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= MASK_NONE;
        end else if (state == POP && !ent_drop) begin
            prog_ba   <= ent_bank;
            prog_addr <= 22'(ent_off >> 1);
            prog_data <= {2{ent_byte}};
            prog_mask <= ent_mask;
        end
    end

    // A fresh download edge wins over the end-of-drain clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_q       <= 1'b0;
            dwnld_busy <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            dl_q <= downloading;
            if (dl_rise)
                dwnld_busy <= 1'b1;
            else if (!downloading && empty && state == IDLE)
                dwnld_busy <= 1'b0;
            if (ioctl_rom_wr && full) overflow <= 1'b1;
            else if (dl_rise)         overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtframe_prog_packer.sv
// Scoreboard bench for jtframe_prog_packer: directed cases plus random traffic.
// Expected writes come from an address-arithmetic model, checked by a monitor.
module tb_jtframe_prog_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        downloading;
    logic        ioctl_rom_wr;
    logic [26:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_rdy;
    logic        prog_we;
    logic        prog_rdy;
    logic [1:0]  prog_ba;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic        dwnld_busy;
    logic        overflow;

    int nvec  = 0;
    int nfail = 0;
    logic [41:0] exp_q[$];

    always #5 clk = ~clk;

    jtframe_prog_packer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .downloading  (downloading),
        .ioctl_rom_wr (ioctl_rom_wr),
        .ioctl_addr   (ioctl_addr),
        .ioctl_dout   (ioctl_dout),
        .ioctl_rdy    (ioctl_rdy),
        .prog_we      (prog_we),
        .prog_rdy     (prog_rdy),
        .prog_ba      (prog_ba),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .prog_mask    (prog_mask),
        .dwnld_busy   (dwnld_busy),
        .overflow     (overflow)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference model: bank = which 1 MiB window, word = offset/2.
    function automatic logic [42:0] model(input int a, input logic [7:0] d);
        int bank;
        int off;
        logic [1:0] mask;
        if (a >= 'h40_0000) return '0;
        bank = a / 'h10_0000;
        off  = a - bank * 'h10_0000;
`ifdef JTFRAME_PROG_SWAP_EN
        mask = (a % 2 == 1) ? 2'b10 : 2'b01;
`else
        mask = (a % 2 == 1) ? 2'b01 : 2'b10;
`endif
        return {1'b1, 2'(bank), 22'(off / 2), d, d, mask};
    endfunction

    task automatic expect_byte(input int a, input logic [7:0] d);
        logic [42:0] m;
        m = model(a, d);
        if (m[42]) exp_q.push_back(m[41:0]);
    endtask

    // Drives one strobe for one cycle; returns #1 after the capturing edge.
    task automatic send(input int a, input logic [7:0] d, input bit keep);
        ioctl_rom_wr = 1'b1;
        ioctl_addr   = 27'(a);
        ioctl_dout   = d;
        if (keep) expect_byte(a, d);
        @(posedge clk); #1;
        ioctl_rom_wr = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
        check(name, 64'(exp_q.size()), 64'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [41:0] got;
        logic [41:0] e;
        if (rst_n && prog_we && prog_rdy) begin
            got = {prog_ba, prog_addr, prog_data, prog_mask};
            nvec++;
            if (exp_q.size() == 0) begin
                nfail++;
                $display("FAIL wr_unexpected: got %h, expected no write", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    nfail++;
                    $display("FAIL wr_data: got %h, expected %h", got, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no end, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int a;
        int sent;
        int we_seen;
        int bnd[8];
        bnd = '{'h0F_FFFF, 'h10_0000, 'h1F_FFFF, 'h20_0000,
                'h2F_FFFF, 'h30_0000, 'h3F_FFFF, 'h40_0000};
        rst_n        = 1'b0;
        downloading  = 1'b0;
        ioctl_rom_wr = 1'b0;
        ioctl_addr   = '0;
        ioctl_dout   = '0;
        prog_rdy     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ioctl_rdy", 64'(ioctl_rdy), 64'd1);
        check("rst_prog_we", 64'(prog_we), 64'd0);
        check("rst_prog_mask", 64'(prog_mask), 64'd3);
        check("rst_prog_ba_addr_data",
              64'({prog_ba, prog_addr, prog_data}), 64'd0);
        check("rst_busy", 64'(dwnld_busy), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: four consecutive bytes, bank 0
        downloading = 1'b1;
        prog_rdy    = 1'b1;
        @(posedge clk); #1;
        check("busy_rise", 64'(dwnld_busy), 64'd1);
        send(0, 8'hAA, 1'b1);
        send(1, 8'hBB, 1'b1);
        send(2, 8'hCC, 1'b1);
        send(3, 8'hDD, 1'b1);
        drain("t1_drain");

        // 2: latency and dropped byte
        send('h20_0005, 8'h5A, 1'b1);
        check("lat_n1", 64'(prog_we), 64'd0);
        @(posedge clk); #1;
        check("lat_n2", 64'(prog_we), 64'd0);
        @(posedge clk); #1;
        check("lat_n3", 64'(prog_we), 64'd1);
        check("t2_ba", 64'(prog_ba), 64'd2);
        check("t2_addr", 64'(prog_addr), 64'd2);
        check("t2_mask", 64'(prog_mask), 64'(model('h20_0005, 8'h5A) & 2'b11));
        drain("t2_drain");
        send('h40_0000, 8'h11, 1'b1);
        we_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (prog_we) we_seen++;
        end
        check("t2_drop_no_we", 64'(we_seen), 64'd0);
        @(posedge clk); #1;

        // 3: stalled SDRAM, upstream obeys ioctl_rdy
        prog_rdy = 1'b0;
        sent = 0;
        for (int i = 0; i < 40; i++) begin
            if (ioctl_rdy) begin
                send($urandom_range(0, 'h3F_FFFF), 8'($urandom), 1'b1);
                sent++;
            end else begin
                @(posedge clk); #1;
            end
        end
        check("t3_accepted", 64'(sent), 64'd15);
        check("t3_ioctl_rdy", 64'(ioctl_rdy), 64'd0);
        check("t3_overflow", 64'(overflow), 64'd0);
        prog_rdy = 1'b1;
        drain("t3_drain");

        // 4: forced bytes into a full FIFO (16 entries + 1 held)
        prog_rdy = 1'b0;
        for (int i = 0; i < 20; i++)
            send($urandom_range(0, 'h3F_FFFF), 8'(i), i < 17);
        check("t4_overflow_set", 64'(overflow), 64'd1);
        prog_rdy = 1'b1;
        drain("t4_drain");
        downloading = 1'b0;
        @(posedge clk); #1;
        downloading = 1'b1;
        @(posedge clk); #1;
        check("t4_overflow_clr", 64'(overflow), 64'd0);

        // 5: download ends with five bytes queued
        prog_rdy = 1'b0;
        for (int i = 0; i < 5; i++) send(16 + i, 8'(8'h60 + i), 1'b1);
        downloading = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t5_busy_hold", 64'(dwnld_busy), 64'd1);
        prog_rdy = 1'b1;
        n = 0;
        for (int i = 0; i < 100 && n < 5; i++) begin
            @(negedge clk);
            if (prog_we) n++;
        end
        check("t5_writes", 64'(n), 64'd5);
        @(posedge clk); #1;
        check("t5_busy_idle", 64'(dwnld_busy), 64'd1);
        @(posedge clk); #1;
        check("t5_busy_clr", 64'(dwnld_busy), 64'd0);

        // random traffic across banks and boundaries
        downloading = 1'b1;
        for (int i = 0; i < 400; i++) begin
            prog_rdy = ($urandom_range(0, 3) != 0);
            if (ioctl_rdy && $urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 3) == 0) a = bnd[$urandom_range(0, 7)];
                else a = $urandom_range(0, 'h47_FFFF);
                send(a, 8'($urandom), 1'b1);
            end else begin
                @(posedge clk); #1;
            end
        end
        prog_rdy = 1'b1;
        drain("rand_drain");
        check("rand_overflow", 64'(overflow), 64'd0);

        // 6: reset in the middle of a write
        prog_rdy = 1'b0;
        for (int i = 0; i < 3; i++) send('h10_0000 + i, 8'(8'hE0 + i), 1'b1);
        for (int i = 0; i < 20 && !prog_we; i++) begin
            @(posedge clk); #1;
        end
        check("t6_in_write", 64'(prog_we), 64'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t6_we_drop", 64'(prog_we), 64'd0);
        check("t6_busy_drop", 64'(dwnld_busy), 64'd0);
        downloading = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        prog_rdy = 1'b1;
        we_seen  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (prog_we) we_seen++;
        end
        check("t6_fifo_empty", 64'(we_seen), 64'd0);
        check("t6_ioctl_rdy", 64'(ioctl_rdy), 64'd1);
        check("final_queue", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
